// File: rtl/alu_chk_pkg.sv
// Shared definitions for the ALU response checker: opcode encodings and FSM state type.
package alu_chk_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_HALT = 2'd3
  } chk_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: the result a correct ALU must produce for (A, B, op).
module alu_ref_model
  import alu_chk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] expected
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves expected unassigned (no latch).
    expected = '0;
    case (op)
      OPW'(OP_ADD): expected = A + B;
      OPW'(OP_SUB): expected = A - B;
      OPW'(OP_AND): expected = A & B;
      OPW'(OP_OR):  expected = A | B;
      OPW'(OP_XOR): expected = A ^ B;
      OPW'(OP_NOT): expected = ~A;
      OPW'(OP_SHL): expected = {A[WIDTH-2:0], 1'b0};
      OPW'(OP_SHR): expected = {1'b0, A[WIDTH-1:1]};
      default:      expected = '0;
    endcase
  end

endmodule

// File: rtl/alu_response_checker.sv
// Checks a stream of observed ALU transactions against alu_ref_model through a
// two-stage pipeline, tallying passes/fails and capturing the first failure.
module alu_response_checker
  import alu_chk_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int OPW          = 3,
  parameter int CNTW         = 16,
  parameter bit HALT_ON_FAIL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [CNTW-1:0]  num_tx,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [OPW-1:0]   aluOp,
  input  logic [WIDTH-1:0] result,
  output logic [CNTW-1:0]  pass_count,
  output logic [CNTW-1:0]  fail_count,
  output logic             mismatch,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             ff_valid,
  output logic [WIDTH-1:0] ff_opA,
  output logic [WIDTH-1:0] ff_opB,
  output logic [WIDTH-1:0] ff_expected,
  output logic [WIDTH-1:0] ff_actual,
  output logic [OPW-1:0]   ff_op
);

  chk_state_e       state;
  logic [CNTW-1:0]  num_tx_q;
  logic [CNTW-1:0]  total;
  logic             p_valid;
  logic [WIDTH-1:0] p_a, p_b, p_res;
  logic [OPW-1:0]   p_op;
  logic [WIDTH-1:0] expected;

  alu_ref_model #(.WIDTH(WIDTH), .OPW(OPW)) u_ref (
    .A        (p_a),
    .B        (p_b),
    .op       (p_op),
    .expected (expected)
  );

  logic            check_now, is_fail, halt_now, finish, accept;
  logic [CNTW-1:0] total_next;

  assign check_now  = (state == S_RUN) && p_valid;
  assign is_fail    = expected != p_res;
  assign total_next = total + CNTW'(check_now);
  assign finish     = check_now && (total_next == num_tx_q);
  assign halt_now   = HALT_ON_FAIL && check_now && is_fail;
  // Accepted-but-unchecked work is at most the one staged entry, so this caps acceptance at num_tx.
  assign accept     = (state == S_RUN) && in_valid && !halt_now &&
                      ((total + CNTW'(p_valid)) < num_tx_q);

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign halted = (state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state       <= S_IDLE;
      num_tx_q    <= '0;
      total       <= '0;
      pass_count  <= '0;
      fail_count  <= '0;
      mismatch    <= 1'b0;
      p_valid     <= 1'b0;
      p_a         <= '0;
      p_b         <= '0;
      p_op        <= '0;
      p_res       <= '0;
      ff_valid    <= 1'b0;
      ff_opA      <= '0;
      ff_opB      <= '0;
      ff_expected <= '0;
      ff_actual   <= '0;
      ff_op       <= '0;
    end else if (clear) begin
      state       <= S_IDLE;
      num_tx_q    <= '0;
      total       <= '0;
      pass_count  <= '0;
      fail_count  <= '0;
      mismatch    <= 1'b0;
      p_valid     <= 1'b0;
      p_a         <= '0;
      p_b         <= '0;
      p_op        <= '0;
      p_res       <= '0;
      ff_valid    <= 1'b0;
      ff_opA      <= '0;
      ff_opB      <= '0;
      ff_expected <= '0;
      ff_actual   <= '0;
      ff_op       <= '0;
    end else begin
      mismatch <= 1'b0;
      p_valid  <= accept;
      if (accept) begin
        p_a   <= operandA;
        p_b   <= operandB;
        p_op  <= aluOp;
        p_res <= result;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            num_tx_q <= num_tx;
            total    <= '0;
            state    <= (num_tx == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (check_now) begin
            total <= total_next;
            if (is_fail) begin
              mismatch <= 1'b1;
              if (fail_count != '1) fail_count <= fail_count + CNTW'(1);
              if (!ff_valid) begin
                ff_valid    <= 1'b1;
                ff_opA      <= p_a;
                ff_opB      <= p_b;
                ff_op       <= p_op;
                ff_expected <= expected;
                ff_actual   <= p_res;
              end
            end else if (pass_count != '1) begin
              pass_count <= pass_count + CNTW'(1);
            end
          end
          if (halt_now)    state <= S_HALT;
          else if (finish) state <= S_DONE;
        end
        default: state <= state;
      endcase
    end
  end

endmodule
